// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and the normalizer state encoding.
package fma_pkg;

  localparam int FMA_SUMW = 158;
  localparam int FMA_CNTW = 9;
  localparam int FMA_EW   = 13;
  localparam int FMA_STEP = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

endpackage

// File: rtl/fma_norm_shift_if.sv
// Upstream (LOP) and downstream (rounding) valid/ready channels of the normalizer.
interface fma_norm_shift_if
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_SUMW,
  parameter int CNTW  = FMA_CNTW,
  parameter int EW    = FMA_EW
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic [CNTW-1:0]  normcnt;
  logic             sumzero;
  logic [EW-1:0]    expin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mant;
  logic [EW-1:0]    expout;
  logic             zero;
  logic             lopcorr;

  modport master (
    output in_valid, sum, normcnt, sumzero, expin, out_ready,
    input  in_ready, out_valid, mant, expout, zero, lopcorr
  );

  modport slave (
    input  in_valid, sum, normcnt, sumzero, expin, out_ready,
    output in_ready, out_valid, mant, expout, zero, lopcorr
  );
endinterface

// File: rtl/fma_norm_stepshift.sv
// Bounded left shifter: shifts by min(i_cnt, STEP) with zero fill, combinational.
// Reports the applied amount so the caller can decrement its remaining count.
module fma_norm_stepshift
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_SUMW,
  parameter int CNTW  = FMA_CNTW,
  parameter int STEP  = FMA_STEP,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_din,
  input  logic [CNTW-1:0]  i_cnt,
  output logic [WIDTH-1:0] o_dout,
  output logic [KW-1:0]    o_k
);
  localparam logic [CNTW-1:0] STEPC = CNTW'(STEP);

  logic [KW-1:0] w_k;

  assign w_k    = (i_cnt > STEPC) ? KW'(STEP) : i_cnt[KW-1:0];
  assign o_k    = w_k;
  assign o_dout = i_din << w_k;

endmodule

// File: rtl/fma_norm_shift.sv
// Iterative normalizer: shifts the sum left by <=STEP bits/cycle, then fixes a one-bit LOP undercount.
// Latency 2+ceil(rem/STEP) cycles (zero sum: 1); one item in flight, result held until out_ready.
module fma_norm_shift
  import fma_pkg::*;
#(
  parameter int WIDTH = FMA_SUMW,
  parameter int CNTW  = FMA_CNTW,
  parameter int EW    = FMA_EW,
  parameter int STEP  = FMA_STEP
) (
  input logic             clk,
  input logic             reset,
  fma_norm_shift_if.slave nrm
);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [CNTW-1:0] MAXCNT = CNTW'(WIDTH - 1);

  norm_state_t      r_state;
  logic [WIDTH-1:0] r_mant;
  logic [EW-1:0]    r_exp;
  logic [CNTW-1:0]  r_rem;
  logic             r_zero;
  logic             r_lopcorr;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_step_mant;
  logic [KW-1:0]    w_step_k;
  logic [CNTW-1:0]  w_clamp_cnt;

  assign w_clamp_cnt = (nrm.normcnt > MAXCNT) ? MAXCNT : nrm.normcnt;

  fma_norm_stepshift #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW),
    .STEP  (STEP),
    .KW    (KW)
  ) u_stepshift (
    .i_din  (r_mant),
    .i_cnt  (r_rem),
    .o_dout (w_step_mant),
    .o_k    (w_step_k)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_zero      <= 1'b0;
      r_lopcorr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (nrm.in_valid) begin
            r_in_ready <= 1'b0;
            r_rem      <= w_clamp_cnt;
            r_lopcorr  <= 1'b0;
            if (nrm.sumzero) begin
              r_mant      <= '0;
              r_exp       <= '0;
              r_zero      <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_mant  <= nrm.sum;
              r_exp   <= nrm.expin;
              r_zero  <= 1'b0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (r_rem != '0) begin
            r_mant <= w_step_mant;
            r_exp  <= r_exp - EW'(w_step_k);
            r_rem  <= r_rem - CNTW'(w_step_k);
          end else begin
            // LOP may undercount by one; the sum then still has a leading zero.
            if (!r_mant[WIDTH-1]) begin
              r_mant    <= {r_mant[WIDTH-2:0], 1'b0};
              r_exp     <= r_exp - EW'(1);
              r_lopcorr <= 1'b1;
            end
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (nrm.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign nrm.in_ready  = r_in_ready;
  assign nrm.out_valid = r_out_valid;
  assign nrm.mant      = r_mant;
  assign nrm.expout    = r_exp;
  assign nrm.zero      = r_zero;
  assign nrm.lopcorr   = r_lopcorr;

endmodule

// File: tb/tb_fma_norm_shift.sv
// Directed vector bench for fma_norm_shift: latency, results, backpressure and mid-flight reset.
module tb_fma_norm_shift;
  import fma_pkg::*;

  localparam int W  = FMA_SUMW;
  localparam int CW = FMA_CNTW;
  localparam int EW = FMA_EW;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TOP1 = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0]  sum;
    logic [CW-1:0] normcnt;
    logic          sumzero;
    logic [EW-1:0] expin;
    int            lat;
    logic [W-1:0]  mant;
    logic [EW-1:0] expout;
    logic          zero;
    logic          lopc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[11];

  fma_norm_shift_if nrm ();

  fma_norm_shift dut (
    .clk   (clk),
    .reset (reset),
    .nrm   (nrm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_exp(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_mant(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [W-1:0] sum, input logic [CW-1:0] cnt, input logic sz,
                               input logic [EW-1:0] ein, input int lat, input logic [W-1:0] mant,
                               input logic [EW-1:0] eout, input logic zero, input logic lopc);
    vec_t v;
    v.sum = sum; v.normcnt = cnt; v.sumzero = sz; v.expin = ein;
    v.lat = lat; v.mant = mant; v.expout = eout; v.zero = zero; v.lopc = lopc;
    return v;
  endfunction

  // Called in the accept cycle's successor (cycle 1); returns the cycle out_valid was seen, 0 on timeout.
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      chk_bit($sformatf("%s in_ready_busy c%0d", tag, c), nrm.in_ready, 1'b0);
      if (nrm.out_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    nrm.sum      = v.sum;
    nrm.normcnt  = v.normcnt;
    nrm.sumzero  = v.sumzero;
    nrm.expin    = v.expin;
    nrm.in_valid = 1'b1;
    nrm.out_ready = 1'b0;
    tick();
    nrm.in_valid = 1'b0;
    wait_result(tag, lat);
    chk_int({tag, " latency"}, lat, v.lat);
    chk_mant({tag, " mant"}, nrm.mant, v.mant);
    chk_exp({tag, " expout"}, nrm.expout, v.expout);
    chk_bit({tag, " zero"}, nrm.zero, v.zero);
    chk_bit({tag, " lopcorr"}, nrm.lopcorr, v.lopc);
    nrm.out_ready = 1'b1;
    tick();
    nrm.out_ready = 1'b0;
    chk_bit({tag, " in_ready_after"}, nrm.in_ready, 1'b1);
    chk_bit({tag, " out_valid_after"}, nrm.out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    nrm.in_valid  = 1'b0;
    nrm.sum       = '0;
    nrm.normcnt   = '0;
    nrm.sumzero   = 1'b0;
    nrm.expin     = '0;
    nrm.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk_bit("rst in_ready", nrm.in_ready, 1'b1);
    chk_bit("rst out_valid", nrm.out_valid, 1'b0);
    chk_mant("rst mant", nrm.mant, '0);
    chk_exp("rst expout", nrm.expout, '0);
    chk_bit("rst zero", nrm.zero, 1'b0);
    chk_bit("rst lopcorr", nrm.lopcorr, 1'b0);

    vecs[0]  = mkv(TOP1, 9'd0, 1'b0, 13'd100, 2, TOP1, 13'd100, 1'b0, 1'b0);
    vecs[1]  = mkv(ONE << 117, 9'd40, 1'b0, 13'd100, 4, TOP1, 13'd60, 1'b0, 1'b0);
    vecs[2]  = mkv(ONE << 117, 9'd39, 1'b0, 13'd100, 4, TOP1, 13'd60, 1'b0, 1'b1);
    vecs[3]  = mkv('0, 9'd0, 1'b1, 13'd77, 1, '0, 13'd0, 1'b1, 1'b0);
    vecs[4]  = mkv(ONE, 9'd157, 1'b0, 13'd0, 7, TOP1, 13'h1F63, 1'b0, 1'b0);
    vecs[5]  = mkv(ONE, 9'd300, 1'b0, 13'd0, 7, TOP1, 13'h1F63, 1'b0, 1'b0);
    vecs[6]  = mkv(ONE << 125, 9'd32, 1'b0, 13'd5, 3, TOP1, 13'h1FE5, 1'b0, 1'b0);
    vecs[7]  = mkv(ONE << 92, 9'd64, 1'b0, 13'd0, 4, TOP1, 13'h1FBF, 1'b0, 1'b1);
    vecs[8]  = mkv((ONE * 3) << 100, 9'd56, 1'b0, 13'd1000, 4, (ONE * 3) << 156, 13'd944, 1'b0, 1'b0);
    vecs[9]  = mkv(ONE << 150, 9'd7, 1'b0, 13'h1000, 3, TOP1, 13'h0FF9, 1'b0, 1'b0);
    vecs[10] = mkv(ONE << 5, 9'd3, 1'b1, 13'd55, 1, '0, 13'd0, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Result stalled for 5 cycles while the next item is already being offered.
    nrm.sum = TOP1; nrm.normcnt = 9'd0; nrm.sumzero = 1'b0; nrm.expin = 13'd100;
    nrm.in_valid = 1'b1;
    nrm.out_ready = 1'b0;
    tick();
    nrm.sum = ONE << 117; nrm.normcnt = 9'd40; nrm.expin = 13'd100;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk_bit($sformatf("bp out_valid c%0d", c), nrm.out_valid, 1'b1);
      chk_bit($sformatf("bp in_ready c%0d", c), nrm.in_ready, 1'b0);
      chk_mant($sformatf("bp mant c%0d", c), nrm.mant, TOP1);
      chk_exp($sformatf("bp expout c%0d", c), nrm.expout, 13'd100);
      tick();
    end
    nrm.out_ready = 1'b1;
    chk_bit("bp out_valid release", nrm.out_valid, 1'b1);
    tick();
    nrm.out_ready = 1'b0;
    chk_bit("bp in_ready idle", nrm.in_ready, 1'b1);
    chk_bit("bp out_valid idle", nrm.out_valid, 1'b0);
    tick();
    nrm.in_valid = 1'b0;
    wait_result("bp2", lat);
    chk_int("bp2 latency", lat, 4);
    chk_mant("bp2 mant", nrm.mant, TOP1);
    chk_exp("bp2 expout", nrm.expout, 13'd60);
    chk_bit("bp2 lopcorr", nrm.lopcorr, 1'b0);
    nrm.out_ready = 1'b1;
    tick();
    nrm.out_ready = 1'b0;

    // Reset during the shift sequence drops the item.
    nrm.sum = ONE; nrm.normcnt = 9'd157; nrm.sumzero = 1'b0; nrm.expin = 13'd0;
    nrm.in_valid = 1'b1;
    tick();
    nrm.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bit("mrst in_ready", nrm.in_ready, 1'b1);
    chk_bit("mrst out_valid", nrm.out_valid, 1'b0);
    chk_mant("mrst mant", nrm.mant, '0);
    chk_exp("mrst expout", nrm.expout, '0);
    chk_bit("mrst lopcorr", nrm.lopcorr, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_bit($sformatf("mrst no_output c%0d", c), nrm.out_valid, 1'b0);
    end
    run_vec(vecs[4], "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
